pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Program-counter register stage sitting directly downstream of the 32-bit PC-source 2:1 mux (PC+4 vs. branch/jump target).
- Registers the selected next PC each cycle, drives the instruction-memory address and the PC+4 value fed back to the mux's "a" input.
- Adds stall hold, a post-reset boot cycle, misaligned-target fault capture and a retired-instruction counter.

Parameters:
- RESET_VEC, 32'h0000_0000, PC value loaded on reset and on fault clear; bits [1:0] must be 0.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk, input, 1, single system clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- next_pc, input, 32, output of the PC-source mux (mux_out).
- stall, input, 1, hold PC this cycle (hazard or memory wait).
- clear_fault, input, 1, leave FAULT and restart at RESET_VEC.
- pc, output, 32, current fetch address (registered).
- pc_plus4, output, 32, pc + 4 (combinational); drives the mux's sequential input.
- valid, output, 1, pc is a legal fetch address this cycle (registered).
- fault, output, 1, misaligned-target fault is latched (registered).
- fault_pc, output, 32, offending next_pc captured on fault (registered).
- instret, output, CNT_W, count of committed PC advances (registered).

Behaviour:
- Reset: rst_n low asynchronously forces pc=RESET_VEC, state=BOOT, valid=0, fault=0, fault_pc=0, instret=0. Reset mid-operation discards all state, including a latched fault.
- States: BOOT, RUN, FAULT (2-bit encoding). valid = (state==RUN), fault = (state==FAULT), both driven from flops.
- BOOT: exactly one cycle. pc holds RESET_VEC. Next state is RUN regardless of stall or next_pc.
- RUN, stall=1: pc and instret hold. next_pc is not checked.
- RUN, stall=0, next_pc[1:0]==0: pc<=next_pc, instret<=instret+1.
- RUN, stall=0, next_pc[1:0]!=0: go to FAULT. fault_pc<=next_pc. pc holds the last good value. instret holds.
- FAULT: pc, instret and fault_pc hold. stall and next_pc are ignored.
- FAULT, clear_fault=1: go to BOOT. pc<=RESET_VEC. fault_pc retains its value until the next fault. instret is not cleared.
- clear_fault in BOOT or RUN: ignored.
- Priority in RUN: stall > misalignment check > advance.
- Arithmetic wrap-around:
  - pc_plus4 wraps modulo 2^32 (pc=32'hFFFF_FFFC gives pc_plus4=0).
  - instret wraps to 0 after 2^CNT_W-1.
- Latency: next_pc accepted at edge N appears on pc after edge N (one cycle). pc_plus4 tracks pc combinationally with zero delay.
- No X propagation: every flop has a reset value; no latches.

Decomposition:
- Shared package holds:
  - state typedef: PC_BOOT=2'd0, PC_RUN=2'd1, PC_FAULT=2'd2.
  - XLEN=32.
  - PC_INC=32'd4.
- The combinational pc+4 adder stays inline; no sub-module needed. The PC-source mux remains a separate existing block instantiated by the datapath.

Test Plan:
- Reset then release, stall=0, next_pc=pc_plus4 -> cycle 0: pc=0, valid=0; cycle 1: valid=1; then pc=0,4,8,12 on successive cycles, instret=1,2,3.
- In RUN at pc=32'h10, stall=1 for 3 cycles with next_pc=32'h40 -> pc stays 32'h10 and instret unchanged for 3 cycles; on stall drop pc=32'h40 the next cycle.
- In RUN, next_pc=32'h0000_0102, stall=0 -> next cycle fault=1, valid=0, fault_pc=32'h102, pc unchanged. Pulse clear_fault -> BOOT with pc=0, valid=0, then RUN with valid=1.
- stall=1 with next_pc=32'h3 -> no fault raised. Drop stall with next_pc=32'h8 -> pc=8, fault stays 0.
- Force pc=32'hFFFF_FFFC by driving next_pc to it -> pc_plus4=0. Feeding next_pc=pc_plus4 gives pc=0 next cycle.
- Pulse rst_n low asynchronously between clock edges while in FAULT -> pc=RESET_VEC, fault=0, fault_pc=0, instret=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// Shared types and constants for the program-counter stage.
package pc_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    PC_BOOT  = 2'd0,
    PC_RUN   = 2'd1,
    PC_FAULT = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_unit.sv
// Program-counter register stage: holds the fetch address, feeds PC+4 back to the
// PC-source mux, and tracks boot, stall hold, misaligned-target faults and retired count.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter int              CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   next_pc,
  input  logic              stall,
  input  logic              clear_fault,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   pc_plus4,
  output logic              valid,
  output logic              fault,
  output logic [XLEN-1:0]   fault_pc,
  output logic [CNT_W-1:0]  instret
);

  pc_state_e         state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   fault_pc_q, fault_pc_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_pc_d = fault_pc_q;
    instret_d  = instret_q;
    case (state_q)
      PC_BOOT: state_d = PC_RUN;
      PC_RUN: begin
        // Stall wins over the alignment check; a misaligned target never reaches pc.
        if (!stall) begin
          if (next_pc[1:0] != 2'b00) begin
            state_d    = PC_FAULT;
            fault_pc_d = next_pc;
          end else begin
            pc_d      = next_pc;
            instret_d = instret_q + CNT_W'(1);
          end
        end
      end
      PC_FAULT: begin
        if (clear_fault) begin
          state_d = PC_BOOT;
          pc_d    = RESET_VEC;
        end
      end
      default: state_d = PC_BOOT;
    endcase
    valid_d = (state_d == PC_RUN);
    fault_d = (state_d == PC_FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PC_BOOT;
      pc_q       <= RESET_VEC;
      fault_pc_q <= '0;
      instret_q  <= '0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_pc_q <= fault_pc_d;
      instret_q  <= instret_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
    end
  end

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + PC_INC;
  assign valid    = valid_q;
  assign fault    = fault_q;
  assign fault_pc = fault_pc_q;
  assign instret  = instret_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed scoreboard bench for pc_unit: stimulus queues expected outputs, a monitor
// pops and compares them on the falling clock edge.
module tb_pc_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] next_pc;
  logic        stall;
  logic        clear_fault;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        valid;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] instret;

  logic        fb;
  logic [31:0] npc_r;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pp4;
    logic        v;
    logic        f;
    logic [31:0] fpc;
    logic [31:0] ir;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass;
  int   n_total;

  assign next_pc = fb ? pc_plus4 : npc_r;

  pc_unit #(
    .RESET_VEC(32'h0000_0000),
    .CNT_W    (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .next_pc    (next_pc),
    .stall      (stall),
    .clear_fault(clear_fault),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .valid      (valid),
    .fault      (fault),
    .fault_pc   (fault_pc),
    .instret    (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
  endtask

  // Monitor: one expected record is presented per cycle; check it mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("pc",       pc,                e.pc);
        cmp("pc_plus4", pc_plus4,          e.pp4);
        cmp("valid",    {31'd0, valid},    {31'd0, e.v});
        cmp("fault",    {31'd0, fault},    {31'd0, e.f});
        cmp("fault_pc", fault_pc,          e.fpc);
        cmp("instret",  instret,           e.ir);
      end
    end
  end

  task automatic push(input logic [31:0] p, input logic [31:0] pp4, input logic v,
                      input logic f, input logic [31:0] fpc, input logic [31:0] ir);
    exp_t e;
    e.pc = p; e.pp4 = pp4; e.v = v; e.f = f; e.fpc = fpc; e.ir = ir;
    exp_q.push_back(e);
  endtask

  // Expect the given outputs for the cycle following the next rising edge.
  task automatic chk(input logic [31:0] p, input logic [31:0] pp4, input logic v,
                     input logic f, input logic [31:0] fpc, input logic [31:0] ir);
    @(posedge clk);
    #1;
    push(p, pp4, v, f, fpc, ir);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; stall = 1'b0; clear_fault = 1'b0; fb = 1'b0; npc_r = 32'h0;

    // Reset state, then boot and sequential fetch with next_pc = pc_plus4.
    chk(32'h0, 32'h4, 0, 0, 32'h0, 0);
    rst_n = 1'b1; fb = 1'b1;
    chk(32'h0,  32'h4,  1, 0, 32'h0, 0);
    chk(32'h4,  32'h8,  1, 0, 32'h0, 1);
    chk(32'h8,  32'hC,  1, 0, 32'h0, 2);
    chk(32'hC,  32'h10, 1, 0, 32'h0, 3);
    chk(32'h10, 32'h14, 1, 0, 32'h0, 4);
    fb = 1'b0; npc_r = 32'h40; stall = 1'b1;

    // Three stalled cycles hold pc and instret.
    chk(32'h10, 32'h14, 1, 0, 32'h0, 4);
    chk(32'h10, 32'h14, 1, 0, 32'h0, 4);
    chk(32'h10, 32'h14, 1, 0, 32'h0, 4);
    stall = 1'b0;
    chk(32'h40, 32'h44, 1, 0, 32'h0, 5);
    npc_r = 32'h0000_0102;

    // Misaligned target faults; FAULT ignores stall/next_pc until cleared.
    chk(32'h40, 32'h44, 0, 1, 32'h102, 5);
    npc_r = 32'h7; stall = 1'b1;
    chk(32'h40, 32'h44, 0, 1, 32'h102, 5);
    clear_fault = 1'b1;
    chk(32'h0, 32'h4, 0, 0, 32'h102, 5);
    clear_fault = 1'b0; npc_r = 32'h3; stall = 1'b1;

    // BOOT lasts one cycle despite stall; misaligned next_pc under stall is harmless.
    chk(32'h0, 32'h4, 1, 0, 32'h102, 5);
    chk(32'h0, 32'h4, 1, 0, 32'h102, 5);
    stall = 1'b0; npc_r = 32'h8;
    chk(32'h8, 32'hC, 1, 0, 32'h102, 6);
    npc_r = 32'hFFFF_FFFC; clear_fault = 1'b1;

    // clear_fault in RUN is ignored; pc_plus4 wraps at the top of the address space.
    chk(32'hFFFF_FFFC, 32'h0, 1, 0, 32'h102, 7);
    clear_fault = 1'b0; fb = 1'b1;
    chk(32'h0, 32'h4, 1, 0, 32'h102, 8);
    fb = 1'b0; npc_r = 32'h20;
    chk(32'h20, 32'h24, 1, 0, 32'h102, 9);
    npc_r = 32'h21;
    chk(32'h20, 32'h24, 0, 1, 32'h21, 9);

    // Asynchronous reset between edges while faulted; checked before the next rising edge.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    push(32'h0, 32'h4, 0, 0, 32'h0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; npc_r = 32'h20; stall = 1'b0;
    chk(32'h0,  32'h4,  1, 0, 32'h0, 0);
    chk(32'h20, 32'h24, 1, 0, 32'h0, 1);

    repeat (2) @(negedge clk);
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
